// File: rtl/stackcalc_pkg.sv
// Shared opcodes, shift directions and sequencer state encoding for the stack calculator.
package stackcalc_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  localparam logic SR_PUSH = 1'b0;
  localparam logic SR_POP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP_A  = 3'd1,
    ST_POP_B  = 3'd2,
    ST_PUSH_A = 3'd3,
    ST_PUSH_B = 3'd4
  } seq_state_e;

  // Entries an opcode needs on the stack before it may run.
  function automatic logic [1:0] op_min_depth(input logic [2:0] op);
    case (op)
      OP_DROP, OP_DUP:                  return 2'd1;
      OP_SWAP, OP_ADD, OP_SUB, OP_AND:  return 2'd2;
      default:                          return 2'd0;
    endcase
  endfunction

  // Opcodes whose net effect needs a free slot.
  function automatic logic op_grows(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_DUP);
  endfunction

endpackage

// File: rtl/shiftreg.sv
// One bit-column of the stack: q_o[0] is the top entry, q_o[1] the second.
module shiftreg
  import stackcalc_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            dir_i,
  input  logic            d_i,
  output logic [SIZE-1:0] q_o
);

  logic [SIZE-1:0] q_q;

  // Push moves entries toward the MSB and loads d at q[0]; pop moves them back and fills zero at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      if (dir_i == SR_POP) begin
        q_q <= {1'b0, q_q[SIZE-1:1]};
      end else begin
        q_q <= {q_q[SIZE-2:0], d_i};
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/stack_alu.sv
// Combinational ALU for the two-operand stack ops; s is the second entry, t the top.
module stack_alu
  import stackcalc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] t_i,
  output logic [WIDTH-1:0] r_o
);

  // Result wraps modulo 2^WIDTH; non-ALU opcodes produce zero.
  always_comb begin
    r_o = '0;
    case (op_i)
      OP_ADD:  r_o = s_i + t_i;
      OP_SUB:  r_o = s_i - t_i;
      OP_AND:  r_o = s_i & t_i;
      default: r_o = '0;
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Command front-end of the stack calculator: checks each opcode against the depth and
// turns it into a sequence of push/pop pulses for the shiftreg bank.
//
// state   | meaning
// IDLE    | ready for a command; single-cycle shifts are issued straight from here
// POP_A   | first pop of a multi-cycle op; issued at accept, never held as a state
// POP_B   | next edge issues the second pop and captures S and R
// PUSH_A  | next edge issues the push of R (ADD/SUB/AND) or T (SWAP)
// PUSH_B  | next edge issues the push of S (SWAP only)
//
// A command can be accepted while the previous op's last shift is still on sr_*, so the
// bank is one shift stale at accept. T is forwarded from that pending shift; S is read
// at the POP_B edge, by which time the bank reflects every earlier op.
module stack_op_sequencer
  import stackcalc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2:0]                 in_op_i,
  input  logic [WIDTH-1:0]           in_imm_i,
  input  logic [WIDTH-1:0]           top_i,
  input  logic [WIDTH-1:0]           second_i,
  output logic                       sr_en_o,
  output logic                       sr_dir_o,
  output logic [WIDTH-1:0]           sr_d_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       err_o,
  output logic                       ovf_o,
  output logic                       unf_o
);

  localparam int DW = $clog2(DEPTH+1);

  seq_state_e       state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] r_q;
  logic             in_ready_q;
  logic             sr_en_q;
  logic             sr_dir_q;
  logic [WIDTH-1:0] sr_d_q;
  logic [DW-1:0]    depth_q;
  logic             err_q;
  logic             ovf_q;
  logic             unf_q;

  logic             accept;
  logic             unf_cond;
  logic             ovf_cond;
  logic [WIDTH-1:0] t_now;
  logic [WIDTH-1:0] alu_r;

  assign accept   = in_valid_i && in_ready_q;
  assign unf_cond = depth_q < DW'(op_min_depth(in_op_i));
  assign ovf_cond = op_grows(in_op_i) && (depth_q == DW'(DEPTH));

  // Top of stack as it will be once any shift currently on sr_* has landed.
  always_comb begin
    t_now = top_i;
    if (sr_en_q) begin
      t_now = (sr_dir_q == SR_PUSH) ? sr_d_q : second_i;
    end
  end

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (op_q),
    .s_i  (second_i),
    .t_i  (t_q),
    .r_o  (alu_r)
  );

  // Sequencer FSM with registered handshake, shift-bus, depth and flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      t_q        <= '0;
      s_q        <= '0;
      r_q        <= '0;
      in_ready_q <= 1'b1;
      sr_en_q    <= 1'b0;
      sr_dir_q   <= SR_PUSH;
      sr_d_q     <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      sr_en_q  <= 1'b0;
      sr_dir_q <= SR_PUSH;
      sr_d_q   <= '0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (unf_cond) begin
              err_q <= 1'b1;
              unf_q <= 1'b1;
            end else if (ovf_cond) begin
              err_q <= 1'b1;
              ovf_q <= 1'b1;
            end else begin
              case (in_op_i)
                OP_PUSH: begin
                  sr_en_q <= 1'b1;
                  sr_d_q  <= in_imm_i;
                  depth_q <= depth_q + DW'(1);
                end
                OP_DUP: begin
                  sr_en_q <= 1'b1;
                  sr_d_q  <= t_now;
                  depth_q <= depth_q + DW'(1);
                end
                OP_DROP: begin
                  sr_en_q  <= 1'b1;
                  sr_dir_q <= SR_POP;
                  depth_q  <= depth_q - DW'(1);
                end
                OP_SWAP, OP_ADD, OP_SUB, OP_AND: begin
                  sr_en_q    <= 1'b1;
                  sr_dir_q   <= SR_POP;
                  depth_q    <= depth_q - DW'(1);
                  op_q       <= in_op_i;
                  t_q        <= t_now;
                  state_q    <= ST_POP_B;
                  in_ready_q <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_POP_B: begin
          sr_en_q  <= 1'b1;
          sr_dir_q <= SR_POP;
          depth_q  <= depth_q - DW'(1);
          s_q      <= second_i;
          r_q      <= alu_r;
          state_q  <= ST_PUSH_A;
        end
        ST_PUSH_A: begin
          sr_en_q <= 1'b1;
          depth_q <= depth_q + DW'(1);
          if (op_q == OP_SWAP) begin
            sr_d_q  <= t_q;
            state_q <= ST_PUSH_B;
          end else begin
            sr_d_q     <= r_q;
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
          end
        end
        ST_PUSH_B: begin
          sr_en_q    <= 1'b1;
          sr_d_q     <= s_q;
          depth_q    <= depth_q + DW'(1);
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign sr_en_o    = sr_en_q;
  assign sr_dir_o   = sr_dir_q;
  assign sr_d_o     = sr_d_q;
  assign depth_o    = depth_q;
  assign err_o      = err_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench: stack_op_sequencer driving a real WIDTH x DEPTH shiftreg bank.
module tb_stack_op_sequencer
  import stackcalc_pkg::*;
;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_imm;
  logic [WIDTH-1:0] top_w;
  logic [WIDTH-1:0] second_w;
  logic             sr_en;
  logic             sr_dir;
  logic [WIDTH-1:0] sr_d;
  logic [DW-1:0]    depth;
  logic             err;
  logic             ovf;
  logic             unf;
  logic [DEPTH-1:0] col_q [WIDTH];

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_imm_i(in_imm), .top_i(top_w), .second_i(second_w),
    .sr_en_o(sr_en), .sr_dir_o(sr_dir), .sr_d_o(sr_d), .depth_o(depth),
    .err_o(err), .ovf_o(ovf), .unf_o(unf)
  );

  for (genvar b = 0; b < WIDTH; b++) begin : g_col
    shiftreg #(.SIZE(DEPTH)) u_col (
      .clk(clk), .rst(rst), .en_i(sr_en), .dir_i(sr_dir), .d_i(sr_d[b]), .q_o(col_q[b])
    );
  end

  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      top_w[b]    = col_q[b][0];
      second_w[b] = col_q[b][1];
    end
  end

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference model: stack as a queue, index 0 = top.
  logic [7:0] mstk[$];
  bit m_unf, m_ovf;

  function automatic bit model_apply(input logic [2:0] op, input logic [7:0] imm);
    logic [7:0] t, s, r;
    int need;
    need = (op == OP_DROP || op == OP_DUP) ? 1 :
           (op == OP_SWAP || op == OP_ADD || op == OP_SUB || op == OP_AND) ? 2 : 0;
    if (mstk.size() < need) begin m_unf = 1; return 1; end
    if ((op == OP_PUSH || op == OP_DUP) && mstk.size() == DEPTH) begin m_ovf = 1; return 1; end
    case (op)
      OP_PUSH: mstk.push_front(imm);
      OP_DROP: void'(mstk.pop_front());
      OP_DUP:  mstk.push_front(mstk[0]);
      OP_SWAP: begin t = mstk[0]; mstk[0] = mstk[1]; mstk[1] = t; end
      OP_ADD, OP_SUB, OP_AND: begin
        t = mstk.pop_front();
        s = mstk.pop_front();
        if (op == OP_ADD) r = s + t;
        else if (op == OP_SUB) r = s - t;
        else r = s & t;
        mstk.push_front(r);
      end
      default: ;
    endcase
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Shift bus must be quiet when no pulse is issued; depth must stay in range.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ((!sr_en && (sr_d != '0 || sr_dir != 1'b0)) || depth > DEPTH) begin
        fails++;
        $display("FAIL idle bus: sr_en=%0b sr_dir=%0b sr_d=0x%0h depth=%0d, expected dir=0 d=0 when sr_en=0 and depth<=%0d",
                 sr_en, sr_dir, sr_d, depth, DEPTH);
      end
      if (sr_en) pulse_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mstk.delete();
    m_unf = 0;
    m_ovf = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] imm, output bit act_err, output bit mdl_err);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("in_ready before issue", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mdl_err = model_apply(op, imm);
    act_err = err;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !sr_en) && n < 20) begin @(posedge clk); #1; n++; end
    check("idle reached", in_ready && !sr_en, 1);
  endtask

  task automatic check_state(input string tag);
    check({tag, " top"},    top_w,    mstk.size() > 0 ? mstk[0] : 8'h00);
    check({tag, " second"}, second_w, mstk.size() > 1 ? mstk[1] : 8'h00);
    check({tag, " depth"},  depth,    mstk.size());
    check({tag, " unf"},    unf,      m_unf);
    check({tag, " ovf"},    ovf,      m_ovf);
  endtask

  function automatic int bank_nonzero();
    int nz = 0;
    for (int b = 0; b < WIDTH; b++) if (col_q[b] != '0) nz++;
    return nz;
  endfunction

  typedef struct {
    bit         rs;
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] top;
    logic [7:0] sec;
    logic [2:0] dep;
    bit         err;
    bit         unf;
    bit         ovf;
  } vec_t;

  vec_t tbl[$];
  logic [2:0] b_op  [4] = '{OP_PUSH, OP_DUP, OP_AND, OP_PUSH};
  logic [7:0] b_imm [4] = '{8'h11, 8'h00, 8'h00, 8'h22};

  initial begin
    bit ae, me;
    int busy, low, stalls;
    logic [DW-1:0] dseen [3];

    //             rs    op       imm    top    sec    dep   err   unf   ovf
    tbl.push_back('{1'b1, OP_NOP,  8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h05, 8'h05, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h03, 8'h03, 8'h05, 3'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_ADD,  8'h00, 8'h08, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, OP_PUSH, 8'h02, 8'h02, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h07, 8'h07, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_SUB,  8'h00, 8'hFB, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, OP_PUSH, 8'hA1, 8'hA1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h5C, 8'h5C, 8'hA1, 3'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_SWAP, 8'h00, 8'hA1, 8'h5C, 3'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, OP_DROP, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h01, 8'h01, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h02, 8'h02, 8'h01, 3'd2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h03, 8'h03, 8'h02, 3'd3, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h04, 8'h04, 8'h03, 3'd4, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_PUSH, 8'h05, 8'h04, 8'h03, 3'd4, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, OP_PUSH, 8'h11, 8'h11, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_DUP,  8'h00, 8'h11, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_AND,  8'h00, 8'h11, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, OP_PUSH, 8'h40, 8'h40, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OP_ADD,  8'h00, 8'h40, 8'h00, 3'd1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_DUP,  8'h00, 8'h40, 8'h40, 3'd2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_DUP,  8'h00, 8'h40, 8'h40, 3'd3, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_DUP,  8'h00, 8'h40, 8'h40, 3'd4, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, OP_DUP,  8'h00, 8'h40, 8'h40, 3'd4, 1'b1, 1'b1, 1'b1});

    rst = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset sr_en", sr_en, 0);
    check("reset sr_dir", sr_dir, 0);
    check("reset sr_d", sr_d, 0);
    check("reset depth", depth, 0);
    check("reset err", err, 0);
    check("reset ovf", ovf, 0);
    check("reset unf", unf, 0);
    rst = 1'b0;

    // Directed vectors, each run to completion.
    foreach (tbl[k]) begin
      if (tbl[k].rs) do_reset();
      issue(tbl[k].op, tbl[k].imm, ae, me);
      check($sformatf("vec%0d err", k), ae, tbl[k].err);
      wait_idle();
      check($sformatf("vec%0d top", k), top_w, tbl[k].top);
      check($sformatf("vec%0d second", k), second_w, tbl[k].sec);
      check($sformatf("vec%0d depth", k), depth, tbl[k].dep);
      check($sformatf("vec%0d unf", k), unf, tbl[k].unf);
      check($sformatf("vec%0d ovf", k), ovf, tbl[k].ovf);
      @(posedge clk); #1;
      check($sformatf("vec%0d err pulse ends", k), err, 0);
    end

    // ADD occupancy: 3 pulses, in_ready low for 2 cycles, depth tracks each pulse.
    do_reset();
    issue(OP_PUSH, 8'h05, ae, me);
    issue(OP_PUSH, 8'h03, ae, me);
    wait_idle();
    issue(OP_ADD, 8'h00, ae, me);
    busy = 0; low = 0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) dseen[c] = depth;
      if (sr_en) busy++;
      if (!in_ready) low++;
      @(posedge clk); #1;
    end
    check("add busy cycles", busy, 3);
    check("add ready-low cycles", low, 2);
    check("add depth pop_a", dseen[0], 1);
    check("add depth pop_b", dseen[1], 0);
    check("add depth push_a", dseen[2], 1);
    check_state("add timing");

    // in_valid held high across PUSH, DUP, AND, PUSH.
    do_reset();
    pulse_cnt = 0; stalls = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_op = b_op[k]; in_imm = b_imm[k];
      for (int g = 0; g < 10 && !in_ready; g++) begin @(posedge clk); #1; stalls++; end
      check($sformatf("b2b%0d ready", k), in_ready, 1);
      @(posedge clk); #1;
      check($sformatf("b2b%0d err", k), err, 0);
    end
    in_valid = 1'b0;
    wait_idle();
    check("b2b top", top_w, 8'h22);
    check("b2b second", second_w, 8'h11);
    check("b2b depth", depth, 2);
    check("b2b stall cycles", stalls, 2);
    check("b2b shift pulses", pulse_cnt, 6);

    // Reset in the POP_B cycle of an ADD, with unf already set.
    do_reset();
    issue(OP_DROP, 8'h00, ae, me);
    issue(OP_PUSH, 8'h05, ae, me);
    issue(OP_PUSH, 8'h03, ae, me);
    wait_idle();
    issue(OP_ADD, 8'h00, ae, me);
    @(posedge clk); #1;
    check("mid-add pop_b pulse", {sr_en, sr_dir}, 2'b11);
    check("mid-add unf before rst", unf, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mstk.delete(); m_unf = 0; m_ovf = 0;
    check("rst abort in_ready", in_ready, 1);
    check("rst abort depth", depth, 0);
    check("rst abort sr_en", sr_en, 0);
    check("rst abort flags", {err, unf, ovf}, 3'b000);
    check("rst abort bank", bank_nonzero(), 0);
    @(posedge clk); #1;
    check("rst abort no leftover shift", sr_en, 0);
    check("rst abort bank later", bank_nonzero(), 0);

    // Random commands against the model, sometimes back-to-back.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = OP_PUSH;
      issue(op, 8'($urandom), ae, me);
      check($sformatf("rand%0d err", n), ae, me);
      if ($urandom_range(0, 2) != 0) begin
        wait_idle();
        check_state($sformatf("rand%0d", n));
      end
    end
    wait_idle();
    check_state("rand final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
